mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Sequences the single-ported, pipelined main memory shared by the I-cache and D-cache.
//  Each cycle it takes at most one of three requests: D-cache store (write-through),
//  D-cache block fill, or I-cache block fill. It drives the memory address and command
//  one word per cycle and steers returning words into the owning cache's data array.
//  Sits between the cache controllers and the 4-cycle pipelined memory model.
// PARAMETERS
//  ADDR_W   16  byte address width
//  DATA_W   16  word width
//  BLK_WORDS 8  words per cache block (16 B); word offset = addr[3:1]
// PORTS
//  clk            in   1       rising-edge clock
//  rst            in   1       synchronous, active-high reset
//  i_miss         in   1       I-cache miss; held until i_fill_done
//  i_miss_addr    in   ADDR_W  missing I address (word offset ignored)
//  d_miss         in   1       D-cache miss; held until d_fill_done
//  d_miss_addr    in   ADDR_W  missing D address (word offset ignored)
//  d_wr           in   1       D store request; held until d_wr_done
//  d_wr_addr      in   ADDR_W  store address
//  d_wr_data      in   DATA_W  store data
//  mem_en         out  1       memory request this cycle
//  mem_wr         out  1       1=write, 0=read (valid when mem_en)
//  mem_addr       out  ADDR_W  memory byte address
//  mem_wdata      out  DATA_W  memory write data
//  mem_rdata      in   DATA_W  returned read data
//  mem_rvalid     in   1       mem_rdata valid this cycle
//  fill_we        out  1       write fill_data into cache selected by fill_sel
//  fill_sel       out  1       0=I-cache, 1=D-cache
//  fill_word      out  3       word index within block
//  fill_data      out  DATA_W  = mem_rdata
//  i_fill_done    out  1       1-cycle pulse: last I word written; I-cache writes tag/valid
//  d_fill_done    out  1       1-cycle pulse: last D word written; D-cache writes tag/valid
//  d_wr_done      out  1       1-cycle pulse: store issued to memory
// BEHAVIOUR
//  States: IDLE, STORE, FILL. rst -> IDLE; counters, owner and all outputs 0.
//  IDLE: priority d_wr > d_miss > i_miss. Grant latches owner and block address
//   ({addr[15:4],4'b0}). Next state: STORE or FILL. No request -> stay in IDLE.
//  STORE (1 cycle): mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data,
//   d_wr_done=1. Next state: IDLE.
//  FILL: issue_cnt issues reads for words 0..7 on consecutive cycles
//   (mem_en=1, mem_wr=0, mem_addr=blk|{issue_cnt,1'b0}); no mem_en after word 7.
//   recv_cnt advances on each mem_rvalid: fill_we=1, fill_word=recv_cnt,
//   fill_sel=owner, fill_data=mem_rdata, all in the same cycle.
//   Issue and receive overlap. On the rvalid with recv_cnt==7: pulse the owner's
//   *_fill_done in that cycle; next state IDLE.
//  IDLE always lasts >=1 cycle between operations. The requester drops its request
//   the cycle after its done pulse, so a completed request is never re-granted.
//  Simultaneous requests: the loser holds its request and is served after the
//   winner completes. Fixed priority; I-side starvation is accepted, because a
//   D stall freezes the pipeline.
//  Request deasserted mid-FILL: the fill still runs to completion.
//  mem_rvalid outside FILL: ignored, including returns still in flight after a
//   mid-operation rst. fill_we stays 0.
//  rst mid-FILL/STORE: next cycle IDLE, counters 0, no done pulse.
//  Outputs registered from state/counters, except fill_we, fill_data and *_fill_done,
//   which are qualified by mem_rvalid.
//  Latency, memory latency 4: store done 1 cycle after grant; fill done
//   1+8+4-1 = 12 cycles after grant.
// STRUCTURE
//  Include file cache_defs.vh: state encodings, BLK_WORDS, OWNER_I/OWNER_D constants.
//  Sub-module blk_word_counter (3-bit, en, clr, last flag), instantiated twice
//   (issue_cnt, recv_cnt). FSM, owner register and output muxing live in mem_arbiter.
// TESTING (memory model: 4-cycle pipelined read latency, 1-cycle write)
//  1 d_miss, addr 0x1234 -> reads 0x1230..0x123E on 8 consecutive cycles;
//    fill_sel=1, fill_word 0..7 in order; d_fill_done 12 cycles after grant.
//  2 i_miss and d_miss raised in the same cycle -> D fill completes first; one IDLE
//    cycle; then I fill; i_fill_done after d_fill_done.
//  3 d_wr (0x00A0, 0xBEEF) together with i_miss -> one write cycle
//    (mem_wr=1, 0x00A0, 0xBEEF) and d_wr_done; then the I fill.
//  4 rst pulsed 3 cycles into a D fill -> IDLE; late mem_rvalid ignored; no fill_we,
//    no done; a re-raised d_miss refills all 8 words.
//  5 i_miss dropped mid-fill -> all 8 words still written; i_fill_done pulses once.
//  6 stray mem_rvalid in IDLE -> no fill_we, no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the cache/memory arbiter: widths, block geometry,
// FSM state encodings and owner codes.
package mem_arbiter_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int BLK_WORDS  = 8;
  localparam int BLK_BYTES  = 16;
  localparam int WORD_IDX_W = 3;

  typedef logic [ADDR_W-1:0]     addr_t;
  typedef logic [DATA_W-1:0]     data_t;
  typedef logic [WORD_IDX_W-1:0] word_idx_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_STORE = 2'd1;
  localparam logic [1:0] ST_FILL  = 2'd2;

  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Byte address of the first word of the block containing addr.
  function automatic addr_t blk_base(input addr_t addr);
    return addr & ~addr_t'(BLK_BYTES - 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_blk_word_counter.sv
// Word index counter within a cache block, with synchronous clear and
// a flag marking the last word of the block.
module blk_word_counter
  import mem_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      clr,
  input  logic      en,
  output word_idx_t cnt,
  output logic      last
);

  word_idx_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + word_idx_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == word_idx_t'(BLK_WORDS - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined memory port between D-cache stores, D-cache fills and
// I-cache fills; fixed priority d_wr > d_miss > i_miss.
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      i_miss,
  input  addr_t     i_miss_addr,
  input  logic      d_miss,
  input  addr_t     d_miss_addr,
  input  logic      d_wr,
  input  addr_t     d_wr_addr,
  input  data_t     d_wr_data,
  output logic      mem_en,
  output logic      mem_wr,
  output addr_t     mem_addr,
  output data_t     mem_wdata,
  input  data_t     mem_rdata,
  input  logic      mem_rvalid,
  output logic      fill_we,
  output logic      fill_sel,
  output word_idx_t fill_word,
  output data_t     fill_data,
  output logic      i_fill_done,
  output logic      d_fill_done,
  output logic      d_wr_done
);

  // state | meaning
  // IDLE  | no operation in progress; arbitrate pending requests
  // STORE | one write cycle for the latched D store
  // FILL  | issue 8 block reads, steer 8 returns into the owner cache

  logic [1:0] state_q, state_d;
  logic       owner_q, owner_d;
  addr_t      blk_q, blk_d;
  addr_t      wr_addr_q, wr_addr_d;
  data_t      wr_data_q, wr_data_d;
  logic       issue_done_q, issue_done_d;

  word_idx_t  issue_cnt, recv_cnt;
  logic       issue_last, recv_last;
  logic       in_fill, in_store, issue_en, recv_en, cnt_clr;

  assign in_fill  = (state_q == ST_FILL);
  assign in_store = (state_q == ST_STORE);
  assign issue_en = in_fill && !issue_done_q;
  // Returns outside FILL belong to an aborted operation and are dropped.
  assign recv_en  = in_fill && mem_rvalid;
  assign cnt_clr  = !in_fill;

  blk_word_counter u_issue_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (issue_en),
    .cnt  (issue_cnt),
    .last (issue_last)
  );

  blk_word_counter u_recv_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .en   (recv_en),
    .cnt  (recv_cnt),
    .last (recv_last)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    blk_d        = blk_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    issue_done_d = issue_done_q;
    case (state_q)
      ST_IDLE: begin
        issue_done_d = 1'b0;
        if (d_wr) begin
          state_d   = ST_STORE;
          owner_d   = OWNER_D;
          wr_addr_d = d_wr_addr;
          wr_data_d = d_wr_data;
        end else if (d_miss) begin
          state_d = ST_FILL;
          owner_d = OWNER_D;
          blk_d   = blk_base(d_miss_addr);
        end else if (i_miss) begin
          state_d = ST_FILL;
          owner_d = OWNER_I;
          blk_d   = blk_base(i_miss_addr);
        end
      end
      ST_STORE: begin
        state_d = ST_IDLE;
      end
      ST_FILL: begin
        if (issue_en && issue_last) begin
          issue_done_d = 1'b1;
        end
        if (recv_en && recv_last) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      blk_q        <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      issue_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      blk_q        <= blk_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      issue_done_q <= issue_done_d;
    end
  end

  always_comb begin
    mem_en    = in_store || issue_en;
    mem_wr    = in_store;
    mem_addr  = '0;
    mem_wdata = '0;
    if (in_store) begin
      mem_addr  = wr_addr_q;
      mem_wdata = wr_data_q;
    end else if (issue_en) begin
      mem_addr = blk_q | addr_t'({issue_cnt, 1'b0});
    end
  end

  assign d_wr_done   = in_store;
  assign fill_we     = recv_en;
  assign fill_sel    = owner_q;
  assign fill_word   = recv_cnt;
  assign fill_data   = recv_en ? mem_rdata : '0;
  assign i_fill_done = recv_en && recv_last && (owner_q == OWNER_I);
  assign d_fill_done = recv_en && recv_last && (owner_q == OWNER_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: 4-cycle pipelined memory model,
// scoreboard of expected memory requests, fill writes and done pulses.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss, d_wr;
  logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rvalid;
  logic        fill_we, fill_sel;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        i_fill_done, d_fill_done, d_wr_done;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr        (d_wr),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .fill_we     (fill_we),
    .fill_sel    (fill_sel),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .i_fill_done (i_fill_done),
    .d_fill_done (d_fill_done),
    .d_wr_done   (d_wr_done)
  );

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'h5AC3;
  endfunction

  // Memory model: a read issued in cycle t returns in cycle t+4.
  bit        pv[4];
  bit [15:0] pa[4];
  logic        stray_rv = 1'b0;
  logic [15:0] stray_data = 16'h0;
  always @(posedge clk) begin
    pv[0] <= mem_en && !mem_wr;
    pa[0] <= mem_addr;
    for (int i = 1; i < 4; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign mem_rvalid = pv[3] | stray_rv;
  assign mem_rdata  = stray_rv ? stray_data : mdata(pa[3]);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic wr; logic [15:0] addr; logic [15:0] data; } mem_exp_t;
  typedef struct packed { logic sel; logic [2:0] word; logic [15:0] data; } fill_exp_t;
  typedef struct { int cyc; int kind; } done_ev_t;
  typedef struct {
    bit d_wr; logic [15:0] wa; logic [15:0] wd;
    bit dm;   logic [15:0] da;
    bit im;   logic [15:0] ia;
    int n_issue; int first_kind; int first_lat; int gap;
  } vec_t;

  mem_exp_t  exp_mem_q[$];
  fill_exp_t exp_fill_q[$];
  int        exp_done_q[$];
  int        rise_q[$];
  done_ev_t  done_ev_q[$];

  int checks = 0, errors = 0;
  int en_cnt = 0, rv_ignored = 0, i_done_cnt = 0;
  logic prev_en = 1'b0;
  mem_exp_t  me;
  fill_exp_t fe;
  int        kind, ed;
  vec_t      vecs[6];
  vec_t      rv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (d_fill_done) d_miss = 1'b0;
    if (i_fill_done) i_miss = 1'b0;
    if (d_wr_done)   d_wr   = 1'b0;
  endtask

  task automatic push_fill(input logic sel, input logic [15:0] a);
    logic [15:0] blk, wa;
    blk = a & 16'hFFF0;
    for (int w = 0; w < 8; w++) begin
      wa = blk | 16'(w * 2);
      exp_mem_q.push_back('{wr: 1'b0, addr: wa, data: 16'h0});
      exp_fill_q.push_back('{sel: sel, word: 3'(w), data: mdata(wa)});
    end
    exp_done_q.push_back(sel ? 1 : 0);
  endtask

  task automatic push_store(input logic [15:0] a, input logic [15:0] d);
    exp_mem_q.push_back('{wr: 1'b1, addr: a, data: d});
    exp_done_q.push_back(2);
  endtask

  task automatic run_vec(input vec_t v);
    int k, eb, rb, db;
    tick();
    k  = cyc;
    eb = en_cnt;
    rb = rise_q.size();
    db = done_ev_q.size();
    d_wr = v.d_wr; d_wr_addr = v.wa; d_wr_data = v.wd;
    d_miss = v.dm; d_miss_addr = v.da;
    i_miss = v.im; i_miss_addr = v.ia;
    if (v.d_wr) push_store(v.wa, v.wd);
    if (v.dm)   push_fill(1'b1, v.da);
    if (v.im)   push_fill(1'b0, v.ia);
    for (int t = 0; t < 100 && (d_wr || d_miss || i_miss); t++) tick();
    chk("req_timeout", 64'({d_wr, d_miss, i_miss}), 64'(0));
    d_wr = 1'b0; d_miss = 1'b0; i_miss = 1'b0;
    repeat (6) tick();
    chk("n_issue", 64'(en_cnt - eb), 64'(v.n_issue));
    chk("done_seen", 64'(done_ev_q.size() > db), 64'(1));
    if (done_ev_q.size() > db) begin
      chk("first_done_kind", 64'(done_ev_q[db].kind), 64'(v.first_kind));
      chk("first_done_lat", 64'(done_ev_q[db].cyc - k), 64'(v.first_lat));
      if (v.gap != 0) begin
        chk("second_rise_seen", 64'(rise_q.size() > rb + 1), 64'(1));
        if (rise_q.size() > rb + 1)
          chk("idle_gap", 64'(rise_q[rb+1] - done_ev_q[db].cyc), 64'(v.gap));
      end
    end
    chk("sb_empty", 64'(exp_mem_q.size() + exp_fill_q.size() + exp_done_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rb, ib;
    //                d_wr  wa       wd       dm    da       im    ia       n  kind lat gap
    vecs[0] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000,  8, 1, 12, 0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h2000, 1'b1, 16'h0456, 16, 1, 12, 2};
    vecs[2] = '{1'b1, 16'h00A0, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 16'h3008,  9, 2,  1, 2};
    vecs[3] = '{1'b1, 16'h0102, 16'h1357, 1'b1, 16'h4444, 1'b1, 16'h5550, 17, 2,  1, 2};
    vecs[4] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFF,  8, 0, 12, 0};
    vecs[5] = '{1'b1, 16'hFFFE, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000,  1, 2,  1, 0};

    rst = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0; d_wr = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_outputs", 64'({mem_en, mem_wr, mem_addr, mem_wdata, fill_we, fill_sel,
                              fill_word, fill_data, i_fill_done, d_fill_done, d_wr_done}), 64'(0));

    fork
      forever begin
        @(negedge clk);
        if (mem_en) begin
          en_cnt++;
          if (!prev_en) rise_q.push_back(cyc);
          chk("mem_req_expected", 64'(exp_mem_q.size() != 0), 64'(1));
          if (exp_mem_q.size() != 0) begin
            me = exp_mem_q.pop_front();
            chk("mem_req", 64'({mem_wr, mem_addr, mem_wdata}), 64'(me));
          end
        end
        prev_en = mem_en;
        if (mem_rvalid && !fill_we) rv_ignored++;
        if (fill_we) begin
          chk("fill_expected", 64'(exp_fill_q.size() != 0), 64'(1));
          if (exp_fill_q.size() != 0) begin
            fe = exp_fill_q.pop_front();
            chk("fill_write", 64'({fill_sel, fill_word, fill_data}), 64'(fe));
          end
        end
        if (i_fill_done || d_fill_done || d_wr_done) begin
          kind = d_wr_done ? 2 : (d_fill_done ? 1 : 0);
          if (i_fill_done) i_done_cnt++;
          done_ev_q.push_back('{cyc, kind});
          chk("done_expected", 64'(exp_done_q.size() != 0), 64'(1));
          if (exp_done_q.size() != 0) begin
            ed = exp_done_q.pop_front();
            chk("done_kind", 64'(kind), 64'(ed));
          end
        end
      end
    join_none

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset three cycles into a D fill: in-flight returns must be dropped.
    tick();
    d_miss_addr = 16'h2468;
    d_miss = 1'b1;
    for (int w = 0; w < 3; w++)
      exp_mem_q.push_back('{wr: 1'b0, addr: 16'h2460 | 16'(w * 2), data: 16'h0});
    repeat (3) tick();
    rst = 1'b1;
    d_miss = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_mid_fill_outputs", 64'({mem_en, mem_wr, mem_addr, fill_we, fill_sel, fill_word,
                                     i_fill_done, d_fill_done, d_wr_done}), 64'(0));
    rb = rv_ignored;
    repeat (8) tick();
    chk("late_rvalid_ignored", 64'(rv_ignored - rb), 64'(3));
    chk("sb_after_abort", 64'(exp_mem_q.size() + exp_fill_q.size() + exp_done_q.size()), 64'(0));
    rv = '{1'b0, 16'h0, 16'h0, 1'b1, 16'h2468, 1'b0, 16'h0, 8, 1, 12, 0};
    run_vec(rv);

    // I request withdrawn mid-fill: the fill still completes, done pulses once.
    tick();
    ib = i_done_cnt;
    i_miss_addr = 16'h0ABC;
    i_miss = 1'b1;
    push_fill(1'b0, 16'h0ABC);
    repeat (4) tick();
    i_miss = 1'b0;
    repeat (16) tick();
    chk("i_done_once", 64'(i_done_cnt - ib), 64'(1));
    chk("sb_after_drop", 64'(exp_mem_q.size() + exp_fill_q.size() + exp_done_q.size()), 64'(0));

    // Stray mem_rvalid while idle.
    tick();
    stray_data = 16'hDEAD;
    stray_rv = 1'b1;
    #1;
    chk("stray_no_fill", 64'({fill_we, fill_data, i_fill_done, d_fill_done}), 64'(0));
    tick();
    stray_rv = 1'b0;
    repeat (3) tick();
    chk("stray_no_state_change", 64'({mem_en, mem_wr, mem_addr, fill_word, d_wr_done}), 64'(0));
    run_vec(vecs[5]);

    chk("sb_final", 64'(exp_mem_q.size() + exp_fill_q.size() + exp_done_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
